// File: rtl/fpu_result_collector.sv
// Collects FP add/sub results at fixed latency, classifies them, and buffers them in a small FIFO.
// Latency: result visible on data_reg_c/csr_out one edge after the tag exits the LATENCY-stage pipe.
// Backpressure: none toward issue; a full FIFO with no same-edge pop drops the result and sets overflow_err.
//
// Ports:
//   clk, rst            clock (rising edge) and synchronous active-high reset
//   issue_valid/op      one-cycle issue pulse and its op tag (0 add, 1 sub)
//   fpu_result          add/sub result bus, sampled on the edge where the tag exits
//   result_ready        consumer pop request (pops when result_valid && result_ready)
//   result_valid        FIFO non-empty
//   data_reg_c          head result, 0 when empty
//   csr_out             {valid, count[2:0], 6'b0, subnormal, op, nan, inf, zero, sign} of head
//   csr_out_we          pulses the cycle after an accepted push or pop
//   overflow_err        sticky drop indicator
//
// Optional feature: define FPU_RESULT_FLAGS_EN to decode and store IEEE-754 class flags per entry.
// Without it csr_out[5] and csr_out[3:0] read 0.
module fpu_result_collector #(
  parameter int REG_WIDTH     = 32,
  parameter int CSR_OUT_WIDTH = 16,
  parameter int LATENCY       = 3,
  parameter int DEPTH         = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     issue_valid,
  input  logic                     issue_op,
  input  logic [REG_WIDTH-1:0]     fpu_result,
  input  logic                     result_ready,
  output logic                     result_valid,
  output logic [REG_WIDTH-1:0]     data_reg_c,
  output logic [CSR_OUT_WIDTH-1:0] csr_out,
  output logic                     csr_out_we,
  output logic                     overflow_err
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  // ---------------------------------------------------------------------------
  // Tag pipe: stage i holds the {valid, op} of the issue sampled i+1 edges ago.
  // ---------------------------------------------------------------------------
  logic [LATENCY-1:0] tag_vld;
  logic [LATENCY-1:0] tag_op;

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld <= '0;
      tag_op  <= '0;
    end else begin
      tag_vld[0] <= issue_valid;
      tag_op[0]  <= issue_op;
      for (int i = 1; i < LATENCY; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_op[i]  <= tag_op[i-1];
      end
    end
  end

  logic exit_vld;
  logic exit_op;
  assign exit_vld = tag_vld[LATENCY-1];
  assign exit_op  = tag_op[LATENCY-1];

  // ---------------------------------------------------------------------------
  // FIFO control
  // ---------------------------------------------------------------------------
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             pop;
  logic             push;
  logic             drop;

  assign full = (count == CNT_W'(DEPTH));
  assign pop  = result_valid && result_ready;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign push = exit_vld && (!full || pop);
  assign drop = exit_vld && full && !pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      csr_out_we   <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      csr_out_we   <= push || pop;
      overflow_err <= overflow_err || drop;
    end
  end

  // ---------------------------------------------------------------------------
  // Entry storage (no reset needed: contents are gated by count)
  // ---------------------------------------------------------------------------
  logic [REG_WIDTH-1:0] mem_dat [DEPTH];
  logic                 mem_op  [DEPTH];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_dat[wr_ptr] <= fpu_result;
      mem_op[wr_ptr]  <= exit_op;
    end
  end

`ifdef FPU_RESULT_FLAGS_EN
  // Flag vector order: {subnormal, nan, inf, zero, sign}
  logic [4:0] mem_flg [DEPTH];
  logic [7:0] res_exp;
  logic       man_nz;
  logic       exp_max;
  logic       exp_zero;
  logic [4:0] res_flg;

  assign res_exp  = fpu_result[30:23];
  assign man_nz   = |fpu_result[22:0];
  assign exp_max  = &res_exp;
  assign exp_zero = ~|res_exp;
  assign res_flg  = {exp_zero && man_nz,
                     exp_max && man_nz,
                     exp_max && !man_nz,
                     exp_zero && !man_nz,
                     fpu_result[31]};

  always_ff @(posedge clk) begin
    if (push) mem_flg[wr_ptr] <= res_flg;
  end
`endif

  // ---------------------------------------------------------------------------
  // Outputs, decoded from registered state
  // ---------------------------------------------------------------------------
  assign result_valid = (count != '0);
  assign data_reg_c   = result_valid ? mem_dat[rd_ptr] : '0;

  logic [2:0] cnt3;
  assign cnt3 = 3'(count);

  always_comb begin
    csr_out = '0;
    if (result_valid) begin
      csr_out[15]    = 1'b1;
      csr_out[14:12] = cnt3;
      csr_out[4]     = mem_op[rd_ptr];
`ifdef FPU_RESULT_FLAGS_EN
      csr_out[5]     = mem_flg[rd_ptr][4];
      csr_out[3]     = mem_flg[rd_ptr][3];
      csr_out[2]     = mem_flg[rd_ptr][2];
      csr_out[1]     = mem_flg[rd_ptr][1];
      csr_out[0]     = mem_flg[rd_ptr][0];
`endif
    end
  end

endmodule

// File: tb/tb_fpu_result_collector.sv
module tb_fpu_result_collector;
  localparam int W = 32;
  localparam int CW = 16;
  localparam int L = 3;
  localparam int D = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          issue_valid;
  logic          issue_op;
  logic [W-1:0]  fpu_result;
  logic          result_ready;
  logic          result_valid;
  logic [W-1:0]  data_reg_c;
  logic [CW-1:0] csr_out;
  logic          csr_out_we;
  logic          overflow_err;

  fpu_result_collector #(.REG_WIDTH(W), .CSR_OUT_WIDTH(CW), .LATENCY(L), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_op(issue_op),
    .fpu_result(fpu_result), .result_ready(result_ready), .result_valid(result_valid),
    .data_reg_c(data_reg_c), .csr_out(csr_out), .csr_out_we(csr_out_we),
    .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: in-flight issues as (exit edge, op) and FIFO as a queue.
  typedef struct packed { logic [31:0] ex; logic op; } tag_t;
  typedef struct packed { logic [31:0] v; logic op; } ent_t;
  tag_t pend[$];
  ent_t q[$];
  bit   m_ovf = 0;
  bit   m_we = 0;
  int   cyc = 0;

  function automatic logic [15:0] exp_csr();
    logic [15:0] c;
    logic [31:0] v;
    int e, m;
    c = 16'h0;
    if (q.size() != 0) begin
      v = q[0].v;
      c[15] = 1'b1;
      c[14:12] = 3'(q.size());
      c[4] = q[0].op;
`ifdef FPU_RESULT_FLAGS_EN
      e = int'((v >> 23) & 32'hFF);
      m = int'(v & 32'h7FFFFF);
      c[5] = (e == 0) && (m != 0);
      c[3] = (e == 255) && (m != 0);
      c[2] = (e == 255) && (m == 0);
      c[1] = (e == 0) && (m == 0);
      c[0] = v[31];
`else
      e = 0;
      m = 0;
`endif
    end
    return c;
  endfunction

  task automatic step(input bit iv, input bit op, input bit rdy, input logic [31:0] res, input bit r);
    tag_t t;
    ent_t en;
    bit ex, eop, pop, pacc;
    int sz;
    issue_valid = iv;
    issue_op = op;
    result_ready = rdy;
    fpu_result = res;
    rst = r;
    @(posedge clk);
    if (r) begin
      pend.delete();
      q.delete();
      m_ovf = 0;
      m_we = 0;
    end else begin
      ex = 0; eop = 0; pacc = 0;
      sz = q.size();
      pop = (sz > 0) && rdy;
      if (pend.size() > 0 && pend[0].ex == 32'(cyc)) begin
        t = pend.pop_front();
        ex = 1;
        eop = t.op;
      end
      if (pop) en = q.pop_front();
      if (ex) begin
        if (sz < D || pop) begin
          q.push_back('{v: res, op: eop});
          pacc = 1;
        end else begin
          m_ovf = 1;
        end
      end
      m_we = pop || pacc;
      if (iv) pend.push_back('{ex: 32'(cyc + L), op: op});
    end
    cyc++;
    #1;
    check("valid", result_valid, q.size() != 0);
    check("data", data_reg_c, (q.size() != 0) ? q[0].v : 32'h0);
    check("csr", csr_out, exp_csr());
    check("csr_we", csr_out_we, m_we);
    check("ovf", overflow_err, m_ovf);
  endtask

  logic [31:0] specials [8] = '{32'h7FC00000, 32'hFF800000, 32'h80000000, 32'h00000001,
                               32'h7F800000, 32'h40000000, 32'h00000000, 32'h807FFFFF};

  initial begin
    logic [31:0] r;
    issue_valid = 0; issue_op = 0; result_ready = 0; fpu_result = 0; rst = 1;
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);

    // Single issue with latency 3: result visible after the third following edge.
    step(1, 0, 0, 32'h40000000, 0);
    step(0, 0, 0, 32'h40000000, 0);
    step(0, 0, 0, 32'h40000000, 0);
    step(0, 0, 0, 32'h40000000, 0);
    check("t1_csr", csr_out, 32'h9000);
    check("t1_data", data_reg_c, 32'h40000000);
    check("t1_we", csr_out_we, 1);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    check("t1_empty", csr_out, 32'h0);

    // Five back-to-back issues with no consumer: overflow on the fifth.
    for (int i = 0; i < 8; i++) step(i < 5, i[0], 0, 32'h3F800000 + i, 0);
    check("t3_cnt", csr_out[14:12], 4);
    check("t3_ovf", overflow_err, 1);
    check("t3_head", data_reg_c, 32'h3F800003);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0);
    check("t3_drain", result_valid, 0);

    // Reset with tags in flight and entries buffered.
    step(1, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) step(i < 5, 1, 0, specials[i], 0);
    step(0, 0, 0, 0, 1);
    check("t5_csr", csr_out, 32'h0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 32'hDEADBEEF, 0);
    check("t5_nopush", result_valid, 0);

    // Randomized traffic including full-FIFO pop/push collisions and classes of interest.
    for (int n = 0; n < 3000; n++) begin
      r = ($urandom_range(0, 1) == 0) ? specials[$urandom_range(0, 7)] : $urandom;
      step($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 2) == 0, r, $urandom_range(0, 299) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
